// File: rtl/spi_master_initiator_if.sv
// spi_master_initiator_if: request/response handshake plus the SPI pins of the
// initiator, bundled so the controller side and the SPI wiring travel together.
//   master modport (the initiator): takes start/rw/addr/wdata/miso,
//                                   drives busy/done/rdata/sclk/cs/mosi
//   slave modport  (host + responder side): the mirror image
interface spi_master_initiator_if;
    logic       start;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       sclk;
    logic       cs;
    logic       mosi;
    logic       miso;

    modport master (
        input  start, rw, addr, wdata, miso,
        output busy, done, rdata, sclk, cs, mosi
    );

    modport slave (
        output start, rw, addr, wdata, miso,
        input  busy, done, rdata, sclk, cs, mosi
    );
endinterface

// File: rtl/spi_master_initiator.sv
// spi_master_initiator: frames one SPI memory transaction per request
// ({addr[6:0], rw} header, optional read turnaround, one data byte) and
// derives sclk from clk with a divide-by-2*CLK_DIV period.
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : spi_master_initiator_if.master (request, status, SPI pins)
//   CLK_DIV    : clk cycles per sclk half-period (1..255)
//   READ_GAP   : turnaround sclk periods before read data (0..3)
// Optional feature: define SPI_MASTER_QUEUE_EN for a one-entry request holder
// that accepts a start while busy and launches it in the done cycle.
module spi_master_initiator #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned READ_GAP = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    spi_master_initiator_if.master        bus
);
    localparam int unsigned PH_W  = 9;
    localparam int unsigned PER_W = 3;
    localparam logic [PH_W-1:0]  PH_RISE   = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0]  PH_HIGH   = PH_W'(CLK_DIV);
    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(2 * CLK_DIV - 1);
    localparam logic [PER_W-1:0] BYTE_LAST = PER_W'(7);
    localparam logic [PER_W-1:0] GAP_LAST  = (READ_GAP == 0) ? PER_W'(0) : PER_W'(READ_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HEADER = 3'd1,
        S_GAP    = 3'd2,
        S_DATA   = 3'd3,
        S_TAIL   = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic [PER_W-1:0]  per_q, per_d;
    logic [15:0]       sreg_q, sreg_d;
    logic [7:0]        rx_q, rx_d;
    logic              rw_q, rw_d;
    logic              sclk_q, sclk_d;
    logic              cs_q, cs_d;
    logic              mosi_q, mosi_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [7:0]        rdata_q, rdata_d;

    logic              per_end;
    logic              in_frame_q, in_frame_d;
    logic              req_go, req_rw;
    logic [6:0]        req_addr;
    logic [7:0]        req_wdata;

    assign per_end    = (ph_q == PH_LAST);
    assign in_frame_q = (state_q == S_HEADER) || (state_q == S_GAP) || (state_q == S_DATA);
    assign in_frame_d = (state_d == S_HEADER) || (state_d == S_GAP) || (state_d == S_DATA);

`ifdef SPI_MASTER_QUEUE_EN
    logic       hold_vld_q, hold_vld_d;
    logic       hold_rw_q, hold_rw_d;
    logic [6:0] hold_addr_q, hold_addr_d;
    logic [7:0] hold_wdata_q, hold_wdata_d;

    // Holder fills only while busy and empty; it drains on the next IDLE cycle
    always_comb begin
        hold_vld_d   = hold_vld_q;
        hold_rw_d    = hold_rw_q;
        hold_addr_d  = hold_addr_q;
        hold_wdata_d = hold_wdata_q;
        if ((state_q == S_IDLE) && hold_vld_q) begin
            hold_vld_d = 1'b0;
        end else if (bus.start && busy_q && !hold_vld_q) begin
            hold_vld_d   = 1'b1;
            hold_rw_d    = bus.rw;
            hold_addr_d  = bus.addr;
            hold_wdata_d = bus.wdata;
        end
    end

    // A held request takes the launch slot over a fresh start
    always_comb begin
        req_go    = bus.start || hold_vld_q;
        req_rw    = hold_vld_q ? hold_rw_q    : bus.rw;
        req_addr  = hold_vld_q ? hold_addr_q  : bus.addr;
        req_wdata = hold_vld_q ? hold_wdata_q : bus.wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_vld_q   <= 1'b0;
            hold_rw_q    <= 1'b0;
            hold_addr_q  <= 7'h00;
            hold_wdata_q <= 8'h00;
        end else begin
            hold_vld_q   <= hold_vld_d;
            hold_rw_q    <= hold_rw_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
        end
    end
`else
    // Without the holder only an IDLE-cycle start can launch a frame
    always_comb begin
        req_go    = bus.start;
        req_rw    = bus.rw;
        req_addr  = bus.addr;
        req_wdata = bus.wdata;
    end
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state: every frame state advances only at an sclk period boundary
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (req_go) state_d = S_HEADER;
            S_HEADER: if (per_end && (per_q == BYTE_LAST))
                          state_d = (rw_q && (READ_GAP != 0)) ? S_GAP : S_DATA;
            S_GAP:    if (per_end && (per_q == GAP_LAST)) state_d = S_DATA;
            S_DATA:   if (per_end && (per_q == BYTE_LAST)) state_d = S_TAIL;
            S_TAIL:   if (per_end) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs and datapath; pins are registered so they line up with state_q
    always_comb begin
        ph_d    = ((state_q == S_IDLE) || per_end) ? PH_W'(0) : ph_q + PH_W'(1);
        per_d   = (state_d != state_q) ? PER_W'(0) : (per_end ? per_q + PER_W'(1) : per_q);
        sreg_d  = sreg_q;
        rx_d    = rx_q;
        rw_d    = rw_q;
        rdata_d = rdata_q;
        mosi_d  = in_frame_q ? mosi_q : 1'b0;
        cs_d    = !in_frame_d;
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_q == S_TAIL) && (state_d == S_IDLE);
        sclk_d  = in_frame_d && (ph_d >= PH_HIGH);

        if ((state_q == S_IDLE) && req_go) begin
            sreg_d = {req_addr, req_rw, req_rw ? 8'h00 : req_wdata};
            rw_d   = req_rw;
            mosi_d = req_addr[6];
        end

        // miso is taken on the edge that raises sclk
        if ((state_q == S_DATA) && (ph_q == PH_RISE)) begin
            rx_d = {rx_q[6:0], bus.miso};
        end

        // mosi moves only on the sclk falling edge (the period boundary)
        if (in_frame_q && per_end) begin
            if (state_d == S_TAIL) begin
                mosi_d = 1'b0;
            end else if (state_d == S_GAP) begin
                mosi_d = 1'b0;
                if (state_q == S_HEADER) sreg_d = {sreg_q[14:0], 1'b0};
            end else if (state_q == S_GAP) begin
                mosi_d = sreg_q[15];
            end else begin
                sreg_d = {sreg_q[14:0], 1'b0};
                mosi_d = sreg_q[14];
            end
        end

        if ((state_q == S_DATA) && (state_d == S_TAIL) && rw_q) begin
            rdata_d = rx_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q    <= '0;
            per_q   <= '0;
            sreg_q  <= 16'h0000;
            rx_q    <= 8'h00;
            rw_q    <= 1'b0;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            ph_q    <= ph_d;
            per_q   <= per_d;
            sreg_q  <= sreg_d;
            rx_q    <= rx_d;
            rw_q    <= rw_d;
            sclk_q  <= sclk_d;
            cs_q    <= cs_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.sclk  = sclk_q;
    assign bus.cs    = cs_q;
    assign bus.mosi  = mosi_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_spi_master_initiator.sv
// tb_spi_master_initiator: two initiators (CLK_DIV=2/READ_GAP=1 and
// CLK_DIV=1/READ_GAP=0) share stimulus; sel picks the one being exercised.
// Expected framing is computed from the transaction fields and divider.
module tb_spi_master_initiator;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spi_master_initiator_if bus_a ();
    spi_master_initiator_if bus_b ();

    spi_master_initiator #(.CLK_DIV(2), .READ_GAP(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    spi_master_initiator #(.CLK_DIV(1), .READ_GAP(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

`ifdef SPI_MASTER_QUEUE_EN
    localparam int Q_EN = 1;
`else
    localparam int Q_EN = 0;
`endif

    logic       start, rw_i, miso;
    logic [6:0] addr_i;
    logic [7:0] wdata_i;
    int         sel;

    assign bus_a.start = start && (sel == 0);
    assign bus_b.start = start && (sel == 1);
    assign bus_a.rw = rw_i;       assign bus_b.rw = rw_i;
    assign bus_a.addr = addr_i;   assign bus_b.addr = addr_i;
    assign bus_a.wdata = wdata_i; assign bus_b.wdata = wdata_i;
    assign bus_a.miso = miso;     assign bus_b.miso = miso;

    logic       o_busy, o_done, o_sclk, o_cs, o_mosi;
    logic [7:0] o_rdata;
    always_comb begin
        if (sel == 0) begin
            o_busy = bus_a.busy; o_done = bus_a.done; o_sclk = bus_a.sclk;
            o_cs = bus_a.cs; o_mosi = bus_a.mosi; o_rdata = bus_a.rdata;
        end else begin
            o_busy = bus_b.busy; o_done = bus_b.done; o_sclk = bus_b.sclk;
            o_cs = bus_b.cs; o_mosi = bus_b.mosi; o_rdata = bus_b.rdata;
        end
    end

    int total = 0;
    int bad   = 0;
    logic [7:0] rdata_m [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (sel=%0d t=%0t)", tag, got, exp, sel, $time);
        end
    endtask

    function automatic int cdiv();
        return (sel == 0) ? 2 : 1;
    endfunction

    function automatic int rgap();
        return (sel == 0) ? 1 : 0;
    endfunction

    // Responder: presents read byte bit i just before data rise i; noise elsewhere
    logic [7:0] resp_byte = 8'h00;
    int         rises_r = 0;
    logic       sclk_prev_r = 1'b0;
    always @(negedge clk) begin
        int idx;
        if (o_cs) rises_r = 0;
        else if (o_sclk && !sclk_prev_r) rises_r++;
        sclk_prev_r = o_sclk;
        idx = rises_r - 8 - rgap();
        if (idx >= 0 && idx < 8) miso = resp_byte[7 - idx];
        else                     miso = 1'($urandom);
    end

    task automatic do_txn(input logic r, input logic [6:0] a, input logic [7:0] w, input logic [7:0] rb);
        int cd, gp, f, busy_n, cs_n, rises, done_at, run, bad_runs, bad_mosi;
        logic [31:0] bits, exp_bits, mask;
        logic prev_sclk, prev_mosi, prev_cs;
        logic [7:0] rd;
        cd = cdiv(); gp = rgap();
        f = r ? 16 + gp : 16;
        resp_byte = rb;
        busy_n = 0; cs_n = 0; rises = 0; done_at = 0; run = 0; bad_runs = 0; bad_mosi = 0;
        bits = 0; rd = 8'h00;
        prev_sclk = 1'b0; prev_mosi = 1'b0; prev_cs = 1'b1;
        @(negedge clk);
        start = 1'b1; rw_i = r; addr_i = a; wdata_i = w;
        @(negedge clk);
        start = 1'b0;
        check("first_cs", 32'(o_cs), 32'd0);
        check("first_busy", 32'(o_busy), 32'd1);
        check("first_mosi", 32'(o_mosi), 32'(a[6]));
        for (int k = 1; k <= 400 && done_at == 0; k++) begin
            if (k > 1) @(negedge clk);
            if (o_busy) busy_n++;
            if (!o_cs) cs_n++;
            if (o_sclk && o_cs) bad_runs++;
            if (o_sclk && !prev_sclk) begin
                rises++;
                bits = {bits[30:0], o_mosi};
            end
            if ((o_mosi !== prev_mosi) && !(prev_sclk && !o_sclk) && !(prev_cs && !o_cs)) bad_mosi++;
            if (!o_cs) begin
                if (k == 1) run = 1;
                else if (o_sclk == prev_sclk) run++;
                else begin
                    if (run != cd) bad_runs++;
                    run = 1;
                end
            end else if (!prev_cs) begin
                if (run != cd || !prev_sclk) bad_runs++;
            end
            if (o_done) begin
                done_at = k;
                rd = o_rdata;
            end
            prev_sclk = o_sclk; prev_mosi = o_mosi; prev_cs = o_cs;
        end
        if (r) rdata_m[sel] = rb;
        mask = (32'd1 << f) - 32'd1;
        exp_bits = r ? ({25'd0, a} << (9 + gp)) | (32'd1 << (8 + gp)) : {16'd0, a, 1'b0, w};
        check("busy_len", 32'(busy_n), 32'(2 * cd * (f + 1)));
        check("cs_low_len", 32'(cs_n), 32'(2 * cd * f));
        check("sclk_rises", 32'(rises), 32'(f));
        check("mosi_bits", bits & mask, exp_bits);
        check("done_delay", 32'(done_at), 32'(2 * cd * (f + 1) + 1));
        check("rdata", 32'(rd), 32'(rdata_m[sel]));
        check("sclk_shape", 32'(bad_runs), 32'd0);
        check("mosi_edges", 32'(bad_mosi), 32'd0);
        @(negedge clk);
        check("done_width", 32'(o_done), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int rises, d1, f2, dones, falls, csl, brises, min_gap, hi_run;
        logic pc, pb, ps;
        rst_n = 1'b0; start = 1'b0; rw_i = 1'b0; addr_i = 7'h00; wdata_i = 8'h00; sel = 0;
        rdata_m[0] = 8'h00; rdata_m[1] = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            check("rst_busy", 32'(o_busy), 32'd0);
            check("rst_done", 32'(o_done), 32'd0);
            check("rst_rdata", 32'(o_rdata), 32'd0);
            check("rst_sclk", 32'(o_sclk), 32'd0);
            check("rst_cs", 32'(o_cs), 32'd1);
            check("rst_mosi", 32'(o_mosi), 32'd0);
        end

        // directed cases
        sel = 0; do_txn(1'b0, 7'h2A, 8'hC3, 8'h00);
        sel = 0; do_txn(1'b1, 7'h11, 8'h77, 8'h5A);
        sel = 1; do_txn(1'b1, 7'h3C, 8'h00, 8'hFF);

        // randomized transactions on both dividers
        for (int i = 0; i < 16; i++) begin
            sel = $urandom_range(0, 1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_txn(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom));
        end

        // reset in the middle of a frame
        sel = 0;
        @(negedge clk);
        start = 1'b1; rw_i = 1'b0; addr_i = 7'h55; wdata_i = 8'h0F;
        @(negedge clk);
        start = 1'b0;
        rises = 0; ps = 1'b0;
        for (int k = 0; k < 200 && rises < 5; k++) begin
            if (o_sclk && !ps) rises++;
            ps = o_sclk;
            if (rises < 5) @(negedge clk);
        end
        check("rst_mid_rises", 32'(rises), 32'd5);
        rst_n = 1'b0;
        #1;
        check("rst_mid_cs", 32'(o_cs), 32'd1);
        check("rst_mid_sclk", 32'(o_sclk), 32'd0);
        check("rst_mid_busy", 32'(o_busy), 32'd0);
        check("rst_mid_mosi", 32'(o_mosi), 32'd0);
        check("rst_mid_rdata", 32'(o_rdata), 32'd0);
        rdata_m[0] = 8'h00; rdata_m[1] = 8'h00;
        dones = 0; csl = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (o_done) dones++;
            if (!o_cs) csl++;
        end
        check("rst_mid_no_done", 32'(dones), 32'd0);
        check("rst_mid_no_frame", 32'(csl), 32'd0);
        do_txn(1'b0, 7'h6B, 8'h99, 8'h00);

        // second start during busy
        sel = 0;
        @(negedge clk);
        start = 1'b1; rw_i = 1'b0; addr_i = 7'h33; wdata_i = 8'hA5;
        @(negedge clk);
        start = 1'b0;
        pc = 1'b1; d1 = 0; f2 = 0; dones = 0; falls = 0; csl = 0;
        for (int k = 1; k <= 260; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 10) begin start = 1'b1; addr_i = 7'h4C; wdata_i = 8'h5A; end
            if (k == 11) start = 1'b0;
            if (pc && !o_cs) begin
                falls++;
                if (falls == 2) f2 = k;
            end
            if (!o_cs) csl++;
            if (o_done) begin
                dones++;
                if (dones == 1) d1 = k;
            end
            pc = o_cs;
        end
        check("b2b_done_at", 32'(d1), 32'd69);
        check("b2b_dones", 32'(dones), 32'(Q_EN + 1));
        check("b2b_frames", 32'(falls), 32'(Q_EN + 1));
        check("b2b_cs_low", 32'(csl), 32'(64 * (Q_EN + 1)));
        check("b2b_second_fall", 32'(f2), (Q_EN != 0) ? 32'(d1 + 1) : 32'd0);

        // start held high continuously
        sel = 1;
        @(negedge clk);
        start = 1'b1; rw_i = 1'b0; addr_i = 7'h0E; wdata_i = 8'h81;
        pc = o_cs; pb = o_busy; falls = 0; brises = 0; dones = 0; hi_run = 0; min_gap = 1000;
        for (int k = 1; k <= 240; k++) begin
            @(negedge clk);
            if (k == 120) start = 1'b0;
            if (pc && !o_cs) begin
                falls++;
                if (falls > 1 && hi_run < min_gap) min_gap = hi_run;
                hi_run = 0;
            end
            if (o_cs) hi_run++;
            if (!pb && o_busy) brises++;
            if (o_done) dones++;
            pc = o_cs; pb = o_busy;
        end
        check("held_min_frames", 32'(falls >= 3), 32'd1);
        check("held_done_per_frame", 32'(dones), 32'(falls));
        check("held_busy_per_frame", 32'(brises), 32'(falls));
        check("held_min_gap", 32'(min_gap), 32'(2 * cdiv() + 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
